// File: rtl/cpu_defs_pkg.sv
// Shared core definitions: bus widths and response-owner encoding used by the
// memory-side arbiters of the five-stage core.
package cpu_defs_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned STRB_W       = 4;
    localparam int unsigned STARVE_CNT_W = 4;

    // Which requester a returning SRAM response belongs to.
    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the IF-stage port, ME-stage port and SRAM port seen by
// sram_port_arbiter.
//   slave  : arbiter view (takes requests and sram_rdata, drives acks and sram_*)
//   master : environment view (requesters plus the SRAM macro)
interface sram_port_arbiter_if;
    import cpu_defs_pkg::*;

    // IF-stage requester
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    // ME-stage requester
    logic              data_req;
    logic              data_wr;
    logic [STRB_W-1:0] data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    // Single-port synchronous SRAM
    logic              sram_en;
    logic [STRB_W-1:0] sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  sram_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output inst_req, inst_addr,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output sram_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );

endinterface

// File: rtl/arb_starve_counter.sv
// Saturating starvation counter for priority arbiters.
//   clk, resetn   : clock, synchronous active-low reset
//   inc_i         : count one more grant to the preferred requester
//   clr_i         : clear (wins over inc_i)
//   limit_i       : threshold to compare against
//   below_limit_o : count < limit_i, i.e. the preferred requester may still win
module arb_starve_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc_i,
    input  logic             clr_i,
    input  logic [Width-1:0] limit_i,
    output logic             below_limit_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign below_limit_o = (cnt_q < limit_i);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM (1-cycle read latency) between the
// IF-stage and ME-stage requesters. ME is preferred; after STARVE_LIMIT
// consecutive data grants with inst_req pending, IF wins once.
//   clk, resetn : clock, synchronous active-low reset
//   bus         : slave view of sram_port_arbiter_if (both requester ports and
//                 the SRAM port); addr_ok and sram_* are combinational from the
//                 requests, data_ok follows acceptance by exactly one cycle.
module sram_port_arbiter
    import cpu_defs_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                clk,
    input logic                resetn,
    sram_port_arbiter_if.slave bus
);

    localparam logic [STARVE_CNT_W-1:0] StarveLimit = STARVE_CNT_W'(STARVE_LIMIT);

    logic   grant_inst, grant_data, below_limit;
    logic   resp_valid_q, resp_valid_d;
    owner_e resp_owner_q, resp_owner_d;

    // Grants are suppressed during reset so nothing is issued or tracked.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (resetn) begin
            if (bus.data_req && (!bus.inst_req || below_limit)) begin
                grant_data = 1'b1;
            end else if (bus.inst_req) begin
                grant_inst = 1'b1;
            end
        end
    end

    arb_starve_counter #(
        .Width (STARVE_CNT_W)
    ) u_starve_counter (
        .clk           (clk),
        .resetn        (resetn),
        .inc_i         (grant_data && bus.inst_req),
        .clr_i         (grant_inst || !bus.inst_req),
        .limit_i       (StarveLimit),
        .below_limit_o (below_limit)
    );

    always_comb begin
        bus.inst_addr_ok = grant_inst;
        bus.data_addr_ok = grant_data;
        bus.sram_en      = grant_inst || grant_data;
        bus.sram_we      = '0;
        bus.sram_addr    = '0;
        bus.sram_wdata   = '0;
        if (grant_data) begin
            bus.sram_we    = bus.data_wr ? bus.data_wstrb : '0;
            bus.sram_addr  = bus.data_addr;
            bus.sram_wdata = bus.data_wdata;
        end else if (grant_inst) begin
            bus.sram_addr  = bus.inst_addr;
        end
    end

    // Remember who owns the SRAM response coming back next cycle.
    always_comb begin
        resp_valid_d = grant_inst || grant_data;
        resp_owner_d = grant_data ? OWNER_DATA : OWNER_INST;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            resp_valid_q <= 1'b0;
            resp_owner_q <= OWNER_INST;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
        end
    end

    always_comb begin
        bus.inst_data_ok = resetn && resp_valid_q && (resp_owner_q == OWNER_INST);
        bus.data_data_ok = resetn && resp_valid_q && (resp_owner_q == OWNER_DATA);
        bus.inst_rdata   = bus.sram_rdata;
        bus.data_rdata   = bus.sram_rdata;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;
    import cpu_defs_pkg::*;

    localparam int Limit = 4;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    sram_port_arbiter_if bus ();
    sram_port_arbiter_if bus0 ();

    sram_port_arbiter #(.STARVE_LIMIT(Limit)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    sram_port_arbiter #(.STARVE_LIMIT(0)) dut0 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        iaok;
        logic        daok;
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        idok;
        logic        ddok;
    } view_t;

    function automatic view_t obs();
        view_t v;
        v.iaok  = bus.inst_addr_ok;
        v.daok  = bus.data_addr_ok;
        v.en    = bus.sram_en;
        v.we    = bus.sram_we;
        v.addr  = bus.sram_addr;
        v.wdata = bus.sram_wdata;
        v.idok  = bus.inst_data_ok;
        v.ddok  = bus.data_data_ok;
        return v;
    endfunction

    task automatic idle();
        bus.inst_req   = 1'b0;
        bus.inst_addr  = '0;
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_wstrb = '0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
        bus.sram_rdata = $urandom;
        bus0.inst_req   = 1'b0;
        bus0.inst_addr  = '0;
        bus0.data_req   = 1'b0;
        bus0.data_wr    = 1'b0;
        bus0.data_wstrb = '0;
        bus0.data_addr  = '0;
        bus0.data_wdata = '0;
        bus0.sram_rdata = '0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.inst_req = 1'b1;
        bus.data_req = 1'b1;
        bus.data_wr = 1'b1;
        bus.data_wstrb = 4'hF;
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.inst_addr_ok, bus.data_addr_ok, bus.sram_en, bus.sram_we} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_grants: got %b want 0",
                     {bus.inst_addr_ok, bus.data_addr_ok, bus.sram_en, bus.sram_we});
        end
        n_checks++;
        if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_data_ok: got %b want 00", {bus.inst_data_ok, bus.data_data_ok});
        end
        @(negedge clk);
        idle();
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_inst();
        logic [31:0] rd;
        idle();
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h1C00_0000;
        #1;
        n_checks++;
        if ({bus.inst_addr_ok, bus.data_addr_ok, bus.sram_en, bus.sram_we} !== 7'b1010000) begin
            n_fail++;
            $display("FAIL single_inst_grant: got %b want 1010000",
                     {bus.inst_addr_ok, bus.data_addr_ok, bus.sram_en, bus.sram_we});
        end
        n_checks++;
        if ({bus.sram_addr, bus.sram_wdata} !== {32'h1C00_0000, 32'h0}) begin
            n_fail++;
            $display("FAIL single_inst_addr: got %h/%h want 1c000000/0",
                     bus.sram_addr, bus.sram_wdata);
        end
        @(negedge clk);
        bus.inst_req = 1'b0;
        rd = $urandom;
        bus.sram_rdata = rd;
        #1;
        n_checks++;
        if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b10 || bus.inst_rdata !== rd) begin
            n_fail++;
            $display("FAIL single_inst_resp: got ok=%b rdata=%h want ok=10 rdata=%h",
                     {bus.inst_data_ok, bus.data_data_ok}, bus.inst_rdata, rd);
        end
        @(negedge clk);
    endtask

    // Both requesters held high; expected pattern D,D,D,D,I repeating.
    task automatic test_contention(input int cycles);
        logic prev_d;
        logic exp_d;
        prev_d = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            bus.inst_req  = 1'b1;
            bus.inst_addr = 32'h0000_1000 + 32'(i * 4);
            bus.data_req  = 1'b1;
            bus.data_wr   = 1'b0;
            bus.data_addr = 32'h0000_8000 + 32'(i * 4);
            #1;
            exp_d = ((i % 5) != 4);
            n_checks++;
            if ({bus.inst_addr_ok, bus.data_addr_ok} !== {!exp_d, exp_d}
                || bus.sram_addr !== (exp_d ? bus.data_addr : bus.inst_addr)) begin
                n_fail++;
                $display("FAIL contention_grant[%0d]: got ok=%b addr=%h want data=%b",
                         i, {bus.inst_addr_ok, bus.data_addr_ok}, bus.sram_addr, exp_d);
            end
            if (i > 0) begin
                n_checks++;
                if ({bus.inst_data_ok, bus.data_data_ok} !== {!prev_d, prev_d}) begin
                    n_fail++;
                    $display("FAIL contention_resp[%0d]: got %b want %b", i,
                             {bus.inst_data_ok, bus.data_data_ok}, {!prev_d, prev_d});
                end
            end
            prev_d = exp_d;
            @(negedge clk);
            n_checks++;
            if (dut.u_starve_counter.cnt_q !== 4'(((i % 5) == 4) ? 0 : (i % 5) + 1)) begin
                n_fail++;
                $display("FAIL contention_cnt[%0d]: got %0d want %0d", i,
                         dut.u_starve_counter.cnt_q, ((i % 5) == 4) ? 0 : (i % 5) + 1);
            end
        end
        idle();
        #1;
        n_checks++;
        if ({bus.inst_data_ok, bus.data_data_ok} !== {!prev_d, prev_d}) begin
            n_fail++;
            $display("FAIL contention_drain: got %b want %b",
                     {bus.inst_data_ok, bus.data_data_ok}, {!prev_d, prev_d});
        end
        @(negedge clk);
    endtask

    task automatic test_write();
        idle();
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_wstrb = 4'b0011;
        bus.data_addr  = 32'h0000_0100;
        bus.data_wdata = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if ({bus.data_addr_ok, bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata}
            !== {2'b11, 4'b0011, 32'h100, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL write_issue: got aok=%b en=%b we=%b addr=%h wdata=%h",
                     bus.data_addr_ok, bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata);
        end
        @(negedge clk);
        bus.data_wstrb = 4'b0000;
        bus.data_addr  = 32'h0000_0104;
        bus.data_wdata = 32'h1234_5678;
        #1;
        n_checks++;
        if ({bus.inst_data_ok, bus.data_data_ok, bus.data_addr_ok, bus.sram_en, bus.sram_we}
            !== 8'b01110000) begin
            n_fail++;
            $display("FAIL write_zero_strb: got %b want 01110000",
                     {bus.inst_data_ok, bus.data_data_ok, bus.data_addr_ok, bus.sram_en,
                      bus.sram_we});
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b01) begin
            n_fail++;
            $display("FAIL write_zero_strb_done: got %b want 01",
                     {bus.inst_data_ok, bus.data_data_ok});
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        idle();
        bus.data_req  = 1'b1;
        bus.data_addr = 32'h0000_0200;
        #1;
        n_checks++;
        if (bus.data_addr_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_data_aok: got %b want 1", bus.data_addr_ok);
        end
        @(negedge clk);
        bus.data_req  = 1'b0;
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h1C00_0004;
        rd = $urandom;
        bus.sram_rdata = rd;
        #1;
        n_checks++;
        if ({bus.inst_addr_ok, bus.inst_data_ok, bus.data_data_ok} !== 3'b101
            || bus.data_rdata !== rd) begin
            n_fail++;
            $display("FAIL b2b_overlap: got aok/idok/ddok=%b rdata=%h want 101/%h",
                     {bus.inst_addr_ok, bus.inst_data_ok, bus.data_data_ok}, bus.data_rdata, rd);
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_inst_resp: got %b want 10", {bus.inst_data_ok, bus.data_data_ok});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        idle();
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h1C00_0008;
        #1;
        n_checks++;
        if (bus.inst_addr_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_accept: got %b want 1", bus.inst_addr_ok);
        end
        @(negedge clk);
        resetn = 1'b0;
        bus.data_req = 1'b1;
        #1;
        n_checks++;
        if ({bus.inst_data_ok, bus.data_data_ok, bus.inst_addr_ok, bus.sram_en} !== 4'b0) begin
            n_fail++;
            $display("FAIL midreset_drop: got %b want 0000",
                     {bus.inst_data_ok, bus.data_data_ok, bus.inst_addr_ok, bus.sram_en});
        end
        @(negedge clk);
        resetn = 1'b1;
        idle();
        #1;
        n_checks++;
        if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_after: got %b want 00", {bus.inst_data_ok, bus.data_data_ok});
        end
        @(negedge clk);
        // Build a streak of 3, reset with inst_req still high, then expect a fresh D,D,D,D,I.
        for (int i = 0; i < 3; i++) begin
            bus.inst_req = 1'b1;
            bus.data_req = 1'b1;
            @(negedge clk);
        end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        n_checks++;
        if (dut.u_starve_counter.cnt_q !== 4'd0) begin
            n_fail++;
            $display("FAIL midreset_cnt: got %0d want 0", dut.u_starve_counter.cnt_q);
        end
        test_contention(5);
    endtask

    task automatic test_limit0();
        for (int i = 0; i < 5; i++) begin
            bus0.inst_req  = 1'b1;
            bus0.inst_addr = 32'h0000_2000 + 32'(i * 4);
            bus0.data_req  = 1'b1;
            bus0.data_addr = 32'h0000_3000;
            #1;
            n_checks++;
            if ({bus0.inst_addr_ok, bus0.data_addr_ok} !== 2'b10
                || bus0.sram_addr !== bus0.inst_addr) begin
                n_fail++;
                $display("FAIL limit0_grant[%0d]: got ok=%b addr=%h want 10/%h", i,
                         {bus0.inst_addr_ok, bus0.data_addr_ok}, bus0.sram_addr, bus0.inst_addr);
            end
            @(negedge clk);
        end
        bus0.inst_req = 1'b0;
        #1;
        n_checks++;
        if ({bus0.inst_addr_ok, bus0.data_addr_ok, bus0.inst_data_ok} !== 3'b011) begin
            n_fail++;
            $display("FAIL limit0_release: got %b want 011",
                     {bus0.inst_addr_ok, bus0.data_addr_ok, bus0.inst_data_ok});
        end
        @(negedge clk);
        idle();
        @(negedge clk);
    endtask

    // Random traffic against a cycle-level model of the arbitration rules.
    task automatic test_random(input int cycles);
        int    streak = 0;
        logic  pend_valid = 1'b0;
        logic  pend_data = 1'b0;
        logic  ihold = 1'b0;
        logic  dhold = 1'b0;
        logic  gi, gd;
        view_t e, o;
        for (int c = 0; c < cycles; c++) begin
            resetn = (($urandom % 40) != 0);
            if (!ihold) begin
                bus.inst_req  = (($urandom % 4) != 0);
                bus.inst_addr = $urandom;
            end
            if (!dhold) begin
                bus.data_req   = (($urandom % 4) != 0);
                bus.data_wr    = $urandom;
                bus.data_wstrb = $urandom;
                bus.data_addr  = $urandom;
                bus.data_wdata = $urandom;
            end
            bus.sram_rdata = $urandom;
            #1;
            gd = resetn && bus.data_req && (!bus.inst_req || streak < Limit);
            gi = resetn && bus.inst_req && !gd;
            e.iaok  = gi;
            e.daok  = gd;
            e.en    = gi || gd;
            e.we    = (gd && bus.data_wr) ? bus.data_wstrb : 4'b0;
            e.addr  = gd ? bus.data_addr : (gi ? bus.inst_addr : 32'h0);
            e.wdata = gd ? bus.data_wdata : 32'h0;
            e.idok  = resetn && pend_valid && !pend_data;
            e.ddok  = resetn && pend_valid && pend_data;
            o = obs();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rand_outputs[%0d]: got %h want %h", c, o, e);
            end
            if (e.idok || e.ddok) begin
                n_checks++;
                if ((e.idok ? bus.inst_rdata : bus.data_rdata) !== bus.sram_rdata) begin
                    n_fail++;
                    $display("FAIL rand_rdata[%0d]: got %h want %h", c,
                             e.idok ? bus.inst_rdata : bus.data_rdata, bus.sram_rdata);
                end
            end
            if (!resetn) begin
                streak     = 0;
                pend_valid = 1'b0;
                ihold      = 1'b0;
                dhold      = 1'b0;
            end else begin
                pend_valid = gi || gd;
                pend_data  = gd;
                streak     = (gd && bus.inst_req) ? ((streak < 15) ? streak + 1 : 15) : 0;
                ihold      = bus.inst_req && !gi;
                dhold      = bus.data_req && !gd;
            end
            @(negedge clk);
        end
        resetn = 1'b1;
        idle();
        @(negedge clk);
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_single_inst();
        test_contention(12);
        test_write();
        test_back_to_back();
        test_reset_midflight();
        test_limit0();
        test_random(600);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port synchronous SRAM between the instruction-fetch requester (IF stage) and the data requester (ME stage) of the five-stage core. Each requester uses a req/addr_ok/data_ok handshake. ME is preferred, with a starvation guard for IF. The SRAM has one-cycle read latency, and the arbiter tracks which requester owns the response returning in each cycle.

## Interface
- `STARVE_LIMIT`, default 4: maximum consecutive data grants issued while `inst_req` is pending. Legal range 0..15.

- `clk`  in  1  core clock
- `resetn`  in  1  synchronous, active-low reset
- `inst_req`  in  1  IF read request
- `inst_addr`  in  32  IF byte address
- `inst_addr_ok`  out  1  IF request accepted this cycle
- `inst_data_ok`  out  1  IF read data valid this cycle
- `inst_rdata`  out  32  IF read data
- `data_req`  in  1  ME request
- `data_wr`  in  1  1 = write, 0 = read
- `data_wstrb`  in  4  byte enables for writes
- `data_addr`  in  32  ME byte address
- `data_wdata`  in  32  ME write data
- `data_addr_ok`  out  1  ME request accepted
- `data_data_ok`  out  1  ME response (read data valid, or write done)
- `data_rdata`  out  32  ME read data
- `sram_en`  out  1  SRAM enable
- `sram_we`  out  4  SRAM byte write enables
- `sram_addr`  out  32  SRAM address
- `sram_wdata`  out  32  SRAM write data
- `sram_rdata`  in  32  SRAM read data, valid one cycle after `sram_en`

## Operation
- **Grant (combinational, each cycle, only while `resetn`=1):**
  - Only one req high: grant it.
  - Both high: grant data if `starve_cnt` < `STARVE_LIMIT`, otherwise grant inst.
  - Neither high: no grant.
- **Granted requester:**
  - Its `addr_ok`=1.
  - `sram_en`=1.
  - `sram_addr`/`sram_wdata` = its addr/wdata; inst wdata = 0.
  - `sram_we` = `data_wstrb` if (data grant and `data_wr`), else 4'b0000.
- **No grant:** `sram_en`=0, `sram_we`=0, `sram_addr`/`sram_wdata` = 0.
- **Requester obligation:** hold req, addr, wr, wstrb and wdata stable until `addr_ok`. The arbiter does not latch inputs.
- **`starve_cnt` (4 bits):**
  - Data grant while `inst_req`=1: increment, saturating at 15.
  - Inst grant, or `inst_req`=0: clear to 0.
  - Otherwise: hold.
- **Response tracking:** registers `resp_valid` (1 bit) and `resp_owner` (1 bit), loaded every cycle with (grant issued, grant target).
- **Response outputs:**
  - `inst_data_ok` = `resp_valid` & owner==INST.
  - `data_data_ok` = `resp_valid` & owner==DATA.
  - `inst_rdata` = `data_rdata` = `sram_rdata`. Meaningful only with the matching `data_ok` and a read.
- **Writes** receive `data_data_ok` one cycle after acceptance, with the same timing as reads.
- **Boundary cases:**
  - Write with `data_wstrb`=0: issued with `sram_en`=1 and `sram_we`=0, completes normally.
  - `STARVE_LIMIT`=0: inst always wins under contention.
  - Back-to-back requests from the same requester may be accepted in consecutive cycles. Throughput is one request per cycle in total.

## Timing
- Request to `addr_ok`: 0 cycles (combinational).
- Acceptance to `data_ok`: exactly 1 cycle.
- No outstanding-request limit beyond 1 in flight per cycle.
- Combinational paths:
  - req → `addr_ok`
  - req → `sram_*`
  - `sram_rdata` → `*_rdata`
- **Reset values (`resetn`=0 at posedge):**
  - `resp_valid`=0, `starve_cnt`=0.
  - While `resetn`=0, all `addr_ok`, `data_ok`, `sram_en` and `sram_we` outputs are forced to 0.
- **Reset mid-operation:** a request accepted in the cycle before the reset edge gets no `data_ok`. The transaction is dropped, and the requesters are reset too.
- **Simultaneous request and response:** a new grant and the previous request's `data_ok` may occur in the same cycle, for either owner.

## Structure
- **Shared package `cpu_defs_pkg`:**
  - `OWNER_INST`=1'b0, `OWNER_DATA`=1'b1
  - `ADDR_W`=32, `DATA_W`=32, `STRB_W`=4
- **Sub-module `arb_starve_counter`:** saturating 4-bit counter with inc/clr/limit-compare outputs. It is reused by future TLB and cache refill arbiters.

## Test plan
- **Idle, then single inst request:** `inst_req`=1, addr 0x1C000000 → `inst_addr_ok` same cycle, `sram_addr`=0x1C000000, `sram_we`=0. Next cycle `inst_data_ok`=1 and `inst_rdata`=`sram_rdata`.
- **Contention, `STARVE_LIMIT`=4:** both reqs held high for 12 cycles → grant pattern D,D,D,D,I repeating. `starve_cnt` goes 1,2,3,4,0.
- **Data write:** `data_wr`=1, `wstrb`=4'b0011, addr 0x100, wdata 0xDEADBEEF → `sram_we`=0011, `sram_wdata`=0xDEADBEEF. `data_data_ok` next cycle, and `inst_data_ok` stays 0.
- **Alternating back-to-back:** cycle n data read, cycle n+1 inst read → at n+1 `data_data_ok`=1 and `inst_addr_ok`=1. At n+2 `inst_data_ok`=1 only.
- **Reset mid-flight:** inst accepted at cycle n, `resetn`=0 sampled at the next edge → no `inst_data_ok`, `resp_valid`=0, `starve_cnt`=0. First grant after `resetn`=1 behaves as from idle.
- **`STARVE_LIMIT`=0 with both reqs high:** inst granted every cycle, `data_addr_ok` stays 0 until `inst_req` drops.
